// File: rtl/huff_pair_sequencer_if.sv
// Handshake and bus bundle for huff_pair_sequencer.
// Groups the granule side info, serial bit input, decoder-bank control/result,
// pair output stream and status. The master side is the environment
// (bitstream source, decoder bank, sink); the slave side is the sequencer.
interface huff_pair_sequencer_if;
    // Granule side info
    logic               start;
    logic [8:0]         big_values;
    logic [8:0]         region1_start;
    logic [8:0]         region2_start;
    logic [4:0]         table_sel0;
    logic [4:0]         table_sel1;
    logic [4:0]         table_sel2;
    logic [11:0]        bit_budget;
    // Serial bitstream
    logic               bit_valid;
    logic               bit_data;
    logic               bit_ready;
    // Decoder bank
    logic [4:0]         dec_sel;
    logic               dec_clr;
    logic               dec_valid;
    logic               dec_data;
    logic               dec_done;
    logic signed [15:0] dec_x;
    logic signed [15:0] dec_y;
    // Pair output stream
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_x;
    logic signed [15:0] out_y;
    logic [9:0]         out_idx;
    // Status
    logic               busy;
    logic               done;
    logic               err_overrun;
    logic [11:0]        bits_used;

    modport master (
        output start, big_values, region1_start, region2_start,
        output table_sel0, table_sel1, table_sel2, bit_budget,
        output bit_valid, bit_data, dec_done, dec_x, dec_y, out_ready,
        input  bit_ready, dec_sel, dec_clr, dec_valid, dec_data,
        input  out_valid, out_x, out_y, out_idx, busy, done, err_overrun, bits_used
    );

    modport slave (
        input  start, big_values, region1_start, region2_start,
        input  table_sel0, table_sel1, table_sel2, bit_budget,
        input  bit_valid, bit_data, dec_done, dec_x, dec_y, out_ready,
        output bit_ready, dec_sel, dec_clr, dec_valid, dec_data,
        output out_valid, out_x, out_y, out_idx, busy, done, err_overrun, bits_used
    );
endinterface

// File: rtl/huff_pair_sequencer.sv
// Huffman big_values pair sequencer.
// Walks the (x,y) pairs of one granule: picks the Huffman table for each pair's
// region, clears the decoder bank at region boundaries, feeds serial bits into
// the selected decoder within a bit budget and presents each decoded pair on a
// valid/ready output stream.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - huff_pair_sequencer_if.slave: side info + start, bit input handshake,
//          decoder bank control/result, pair output stream, busy/done/status
module huff_pair_sequencer #(
    parameter int unsigned MAX_PAIRS = 288
) (
    input logic                 clk,
    input logic                 rst,
    huff_pair_sequencer_if.slave bus
);
    localparam logic [8:0] MaxPairs = 9'(MAX_PAIRS);

    typedef enum logic [2:0] {StIdle, StLoad, StFeed, StEmit, StFin} state_t;

    state_t             state_q, state_d;
    logic [8:0]         pair_cnt_q, pair_cnt_d;
    logic [11:0]        bits_used_q, bits_used_d;
    logic [8:0]         bv_q, bv_d;
    logic [8:0]         r1_q, r1_d;
    logic [8:0]         r2_q, r2_d;
    logic [4:0]         t0_q, t0_d;
    logic [4:0]         t1_q, t1_d;
    logic [4:0]         t2_q, t2_d;
    logic [11:0]        budget_q, budget_d;
    logic signed [15:0] out_x_q, out_x_d;
    logic signed [15:0] out_y_q, out_y_d;
    logic [9:0]         out_idx_q, out_idx_d;
    logic               err_q, err_d;
    logic               done_q;

    logic [4:0] cur_sel;
    logic [8:0] pair_nxt;
    logic [8:0] bv_in;
    logic       feed_rdy;

    always_comb begin
        if (pair_cnt_q < r1_q) begin
            cur_sel = t0_q;
        end else if (pair_cnt_q < r2_q) begin
            cur_sel = t1_q;
        end else begin
            cur_sel = t2_q;
        end
    end

    assign pair_nxt = pair_cnt_q + 9'd1;
    assign bv_in    = (bus.big_values > MaxPairs) ? MaxPairs : bus.big_values;

    always_comb begin
        state_d     = state_q;
        pair_cnt_d  = pair_cnt_q;
        bits_used_d = bits_used_q;
        bv_d        = bv_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        budget_d    = budget_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_idx_d   = out_idx_q;
        err_d       = err_q;
        feed_rdy    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    bv_d        = bv_in;
                    r1_d        = bus.region1_start;
                    r2_d        = bus.region2_start;
                    t0_d        = bus.table_sel0;
                    t1_d        = bus.table_sel1;
                    t2_d        = bus.table_sel2;
                    budget_d    = bus.bit_budget;
                    pair_cnt_d  = '0;
                    bits_used_d = '0;
                    err_d       = 1'b0;
                    state_d     = (bv_in == 9'd0) ? StFin : StLoad;
                end
            end
            StLoad: begin
                // Table 0 codes an all-zero region: no bits to decode.
                if (cur_sel == 5'd0) begin
                    out_x_d   = '0;
                    out_y_d   = '0;
                    out_idx_d = {pair_cnt_q, 1'b0};
                    state_d   = StEmit;
                end else begin
                    state_d = StFeed;
                end
            end
            StFeed: begin
                // A table-0 pair reached without a region boundary is still all zero.
                if (cur_sel == 5'd0) begin
                    out_x_d   = '0;
                    out_y_d   = '0;
                    out_idx_d = {pair_cnt_q, 1'b0};
                    state_d   = StEmit;
                end else if (bus.dec_done) begin
                    out_x_d   = bus.dec_x;
                    out_y_d   = bus.dec_y;
                    out_idx_d = {pair_cnt_q, 1'b0};
                    state_d   = StEmit;
                end else if (bits_used_q == budget_q) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    feed_rdy = 1'b1;
                    if (bus.bit_valid) begin
                        bits_used_d = bits_used_q + 12'd1;
                    end
                end
            end
            StEmit: begin
                if (bus.out_ready) begin
                    pair_cnt_d = pair_nxt;
                    if (pair_nxt == bv_q) begin
                        state_d = StFin;
                    end else if ((pair_nxt == r1_q) || (pair_nxt == r2_q)) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StFeed;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pair_cnt_q  <= '0;
            bits_used_q <= '0;
            bv_q        <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            budget_q    <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_idx_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pair_cnt_q  <= pair_cnt_d;
            bits_used_q <= bits_used_d;
            bv_q        <= bv_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            budget_q    <= budget_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_idx_q   <= out_idx_d;
            err_q       <= err_d;
            // done is registered off FIN so it is glitch-free and one cycle wide.
            done_q      <= (state_q == StFin);
        end
    end

    assign bus.bit_ready   = feed_rdy;
    assign bus.dec_valid   = feed_rdy & bus.bit_valid;
    assign bus.dec_data    = feed_rdy & bus.bit_valid & bus.bit_data;
    assign bus.dec_clr     = rst | (state_q == StLoad);
    assign bus.dec_sel     = cur_sel;
    assign bus.out_valid   = (state_q == StEmit);
    assign bus.out_x       = out_x_q;
    assign bus.out_y       = out_y_q;
    assign bus.out_idx     = out_idx_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.err_overrun = err_q;
    assign bus.bits_used   = bits_used_q;
endmodule

// File: tb/tb_huff_pair_sequencer.sv
// Self-checking bench for huff_pair_sequencer with a scoreboard of expected pairs.
// A toy 4-bit decoder stands in for the table bank: bits b0 b1 b2 s give
// x = 2*b0 + b1 and y = s ? -b2 : b2.
module tb_huff_pair_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    huff_pair_sequencer_if bus ();

    huff_pair_sequencer #(
        .MAX_PAIRS(288)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [9:0]         idx;
    } pair_t;

    pair_t      sb[$];
    bit         bitq[$];
    logic [4:0] selq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    int stall_cfg = 0;
    bit use_force = 0;
    logic [3:0] force_w = 4'b0000;

    bit drv_pop = 0;
    bit drv_was_valid = 0;
    int drv_stall = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Toy decoder bank model
    logic [2:0] dshift;
    int         dcnt;
    always @(posedge clk) begin
        if (bus.dec_clr || bus.dec_done) begin
            dcnt         <= 0;
            bus.dec_done <= 1'b0;
        end else if (bus.dec_valid) begin
            dshift <= {dshift[1:0], bus.dec_data};
            dcnt   <= dcnt + 1;
            if (dcnt == 3) begin
                bus.dec_done <= 1'b1;
                bus.dec_x    <= 16'({14'd0, dshift[2:1]});
                bus.dec_y    <= (bus.dec_data && dshift[0]) ? -16'sd1 : 16'({15'd0, dshift[0]});
            end
        end
    end

    // Bit source, output sink and per-cycle monitor
    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (drv_pop && bitq.size() > 0) begin
                void'(bitq.pop_front());
                void'(selq.pop_front());
            end
            bus.bit_valid = (bitq.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.bit_data  = (bitq.size() > 0) ? bitq[0] : 1'b0;
            if (bus.out_valid && !drv_was_valid) drv_stall = stall_cfg;
            else if (drv_stall > 0) drv_stall--;
            bus.out_ready = (drv_stall == 0);
            #1;
            drv_pop = bus.bit_valid && bus.bit_ready;
            if (drv_pop) begin
                check_eq("dec_valid", bus.dec_valid, 1);
                check_eq("dec_data", bus.dec_data, bus.bit_data);
                check_eq("dec_sel", bus.dec_sel, selq[0]);
            end
            if (bus.out_valid) begin
                check_eq("bit_ready_in_emit", bus.bit_ready, 0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_out_valid", 1, 0);
                end else begin
                    check_eq("out_x", bus.out_x, sb[0].x);
                    check_eq("out_y", bus.out_y, sb[0].y);
                    check_eq("out_idx", bus.out_idx, sb[0].idx);
                    if (bus.out_ready) void'(sb.pop_front());
                end
                drv_was_valid = !bus.out_ready;
            end else begin
                drv_was_valid = 1'b0;
            end
            if (bus.dec_clr && !rst) clr_cnt++;
            if (bus.done) done_cnt++;
        end
    end

    task automatic scramble();
        bus.big_values    = 9'($urandom);
        bus.region1_start = 9'($urandom);
        bus.region2_start = 9'($urandom);
        bus.table_sel0    = 5'($urandom);
        bus.table_sel1    = 5'($urandom);
        bus.table_sel2    = 5'($urandom);
        bus.bit_budget    = 12'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_out_x"}, bus.out_x, 0);
        check_eq({tag, "_out_y"}, bus.out_y, 0);
        check_eq({tag, "_out_idx"}, bus.out_idx, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_err"}, bus.err_overrun, 0);
        check_eq({tag, "_bit_ready"}, bus.bit_ready, 0);
        check_eq({tag, "_dec_valid"}, bus.dec_valid, 0);
        check_eq({tag, "_dec_data"}, bus.dec_data, 0);
        check_eq({tag, "_dec_sel"}, bus.dec_sel, 0);
        check_eq({tag, "_bits_used"}, bus.bits_used, 0);
        check_eq({tag, "_dec_clr"}, bus.dec_clr, 1);
    endtask

    // Builds expected pairs/bits for one granule, then kicks it off.
    task automatic launch(input int bv, input int r1, input int r2, input int t0,
                          input int t1, input int t2, input int budget,
                          output int exp_bits, output bit exp_err, output int exp_loads);
        int  used = 0;
        bit  ovr = 0;
        int  loads = 0;
        int  sel;
        bit  b[4];
        pair_t e;
        for (int p = 0; p < bv && !ovr; p++) begin
            sel = (p < r1) ? t0 : ((p < r2) ? t1 : t2);
            if (p == 0 || p == r1 || p == r2) loads++;
            if (sel != 0) begin
                for (int k = 0; k < 4; k++) begin
                    b[k] = (use_force && p == 0) ? force_w[3-k] : 1'($urandom);
                    bitq.push_back(b[k]);
                    selq.push_back(5'(sel));
                end
                if (used + 4 > budget) begin
                    ovr  = 1;
                    used = budget;
                end else begin
                    used += 4;
                    e.x   = 16'(2 * int'(b[0]) + int'(b[1]));
                    e.y   = b[3] ? -16'(b[2]) : 16'(b[2]);
                    e.idx = 10'(2 * p);
                    sb.push_back(e);
                end
            end else begin
                e.x   = '0;
                e.y   = '0;
                e.idx = 10'(2 * p);
                sb.push_back(e);
            end
        end
        exp_bits  = used;
        exp_err   = ovr;
        exp_loads = loads;
        done_cnt  = 0;
        clr_cnt   = 0;
        bus.big_values    = 9'(bv);
        bus.region1_start = 9'(r1);
        bus.region2_start = 9'(r2);
        bus.table_sel0    = 5'(t0);
        bus.table_sel1    = 5'(t1);
        bus.table_sel2    = 5'(t2);
        bus.bit_budget    = 12'(budget);
        bus.start         = 1'b1;
        @(negedge clk); #2;
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic run_granule(input string tag, input int bv, input int r1, input int r2,
                               input int t0, input int t1, input int t2, input int budget,
                               input int stall, input bit poke);
        int exp_bits;
        bit exp_err;
        int exp_loads;
        int waited = 0;
        stall_cfg = stall;
        launch(bv, r1, r2, t0, t1, t2, budget, exp_bits, exp_err, exp_loads);
        check_eq({tag, "_busy_after_start"}, bus.busy, 1);
        if (bv == 0) begin
            check_eq({tag, "_done_early"}, bus.done, 0);
            @(negedge clk); #2;
            check_eq({tag, "_done_latency"}, bus.done, 1);
        end
        if (poke) begin
            repeat (2) @(negedge clk);
            #2;
            check_eq({tag, "_busy_at_poke"}, bus.busy, 1);
            bus.start = 1'b1;
            @(negedge clk); #2;
            bus.start = 1'b0;
            scramble();
        end
        while (done_cnt == 0 && waited < 4000) begin
            @(negedge clk); #2;
            waited++;
        end
        check_eq({tag, "_done_seen"}, (done_cnt != 0), 1);
        repeat (3) @(negedge clk);
        #2;
        check_eq({tag, "_done_pulses"}, done_cnt, 1);
        check_eq({tag, "_bits_used"}, bus.bits_used, exp_bits);
        check_eq({tag, "_err_overrun"}, bus.err_overrun, exp_err);
        check_eq({tag, "_busy_end"}, bus.busy, 0);
        check_eq({tag, "_pairs_left"}, sb.size(), 0);
        check_eq({tag, "_dec_clr_pulses"}, clr_cnt, exp_loads);
        bitq.delete();
        selq.delete();
        sb.delete();
        use_force = 0;
    endtask

    initial begin
        int exp_bits;
        bit exp_err;
        int exp_loads;
        int waited;
        bus.start = 1'b0;
        scramble();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk); #2;

        use_force = 1;
        force_w   = 4'b0111;
        run_granule("t6_pair", 1, 300, 300, 6, 6, 6, 4095, 0, 0);
        run_granule("region_switch", 3, 1, 2, 0, 6, 6, 4095, 0, 0);
        run_granule("backpressure", 4, 400, 400, 6, 6, 6, 4095, 5, 0);
        run_granule("overrun", 1, 300, 300, 6, 6, 6, 2, 0, 0);
        run_granule("overrun_pair2", 3, 300, 300, 6, 6, 6, 6, 1, 0);
        run_granule("exact_budget", 1, 300, 300, 6, 6, 6, 4, 0, 0);
        run_granule("zero_pairs", 0, 300, 300, 6, 6, 6, 4095, 0, 0);
        run_granule("start_while_busy", 5, 2, 2, 6, 3, 9, 4095, 1, 1);
        run_granule("t0_mid_region", 3, 2, 2, 0, 6, 6, 4095, 0, 0);
        run_granule("starts_past_end", 4, 9, 400, 5, 7, 8, 4095, 2, 0);
        run_granule("starts_at_zero", 2, 0, 0, 1, 2, 7, 4095, 0, 0);

        // Reset in the middle of FEED
        stall_cfg = 0;
        launch(2, 300, 300, 6, 6, 6, 4095, exp_bits, exp_err, exp_loads);
        waited = 0;
        while (bus.bits_used < 12'd2 && waited < 200) begin
            @(negedge clk); #2;
            waited++;
        end
        check_eq("rst_mid_bits_reached", (bus.bits_used >= 12'd2), 1);
        rst = 1'b1;
        @(negedge clk); #2;
        check_reset_outputs("rst_mid");
        check_eq("rst_mid_no_done", done_cnt, 0);
        bitq.delete();
        selq.delete();
        sb.delete();
        rst = 1'b0;
        run_granule("after_rst", 2, 1, 300, 6, 4, 4, 4095, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
